universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised universal shift register. Generalises the fixed 8-bit right-shift register to any width, with the following operations:
- bidirectional shift and rotate
- parallel load and synchronous clear
- clock enable
- a frame counter that pulses when WIDTH serial bits have been shifted in since the last load or clear.

It is the serial/parallel conversion stage for the serial-link and display-driver labs that follow.

## Interface
- `WIDTH`, default 8: register width; legal range ≥ 2.
- `RESET_VALUE`, default `'0`: value of Q after reset; WIDTH bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: operation enable; when low, the register and counter hold.
- `mode` input 3: operation select (see Operation).
- `D` input WIDTH: parallel load data.
- `sInR` input 1: serial input entering Q[WIDTH-1] on a right shift.
- `sInL` input 1: serial input entering Q[0] on a left shift.
- `Q` output WIDTH: register contents.
- `sOutR` output 1: equals Q[0] (combinational from Q).
- `sOutL` output 1: equals Q[WIDTH-1] (combinational from Q).
- `frame` output 1: registered, one-cycle pulse on completion of WIDTH shift operations.

## Operation
Mode encoding applies when `en`=1 at a rising edge:
- 000 HOLD: Q unchanged.
- 001 SHR: Q <= {sInR, Q[WIDTH-1:1]}.
- 010 SHL: Q <= {Q[WIDTH-2:0], sInL}.
- 011 ROR: Q <= {Q[0], Q[WIDTH-1:1]}.
- 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 101 LOAD: Q <= D.
- 110 CLEAR: Q <= 0.
- 111: reserved; behaves as HOLD.

Frame counter:
- Internal count `cnt`, range 0..WIDTH-1, width $clog2(WIDTH).
- Each executed SHR, SHL, ROR or ROL increments `cnt`.
- A shift executed with `cnt`=WIDTH-1 wraps `cnt` to 0 and sets `frame`=1 for the following cycle.
- LOAD and CLEAR force `cnt`=0 and `frame`=0.
- HOLD, reserved mode, or `en`=0: `cnt` unchanged, `frame`=0.

Reset:
- Asserting `rst` forces Q=RESET_VALUE, `cnt`=0 and `frame`=0 immediately, independent of `clk`.
- `rst` has priority over every mode and over `en`. A frame in progress is discarded.
- After `rst` deasserts, the first rising edge performs the selected operation normally.

## Timing
- Latency is one cycle for every mode: Q reflects the operation after the rising edge at which it was sampled.
- `sOutR` and `sOutL` follow Q combinationally, with no added cycle.
- `frame` is high for exactly one cycle, starting at the edge that executes the WIDTH-th shift. It therefore coincides with Q holding the complete shifted word.
- Back-to-back frames with continuous shifting pulse `frame` every WIDTH cycles, never on two consecutive cycles (WIDTH ≥ 2).
- `en` low cycles stretch a frame but do not reset it.
- Inputs must be stable around the rising edge of `clk`. `rst` may change at any time.

## Structure
- Package `usr_pkg`: typedef enum `usr_mode_t` for the 3-bit mode encoding, with constants MODE_HOLD … MODE_CLEAR.
- Sub-module `usr_frame_counter`:
  - parameter WIDTH.
  - ports: `clk`, `rst`, `step` (a shift executed), `restart` (LOAD/CLEAR), `frame`.
- The top level contains the next-state mux for Q and instantiates the counter.

## Test plan
All scenarios use WIDTH=8, RESET_VALUE=0.
1. Reset: drive LOAD with D=8'hFF, then assert `rst` mid-cycle -> Q=8'h00 and `frame`=0 before the next clock edge. The first edge after release with LOAD D=8'h3C -> Q=8'h3C.
2. Right shift: LOAD 8'hA5, then three SHR with sInR=1 -> Q = A5, D2, E9, F4 and sOutR = 1, 0, 1, 0.
3. Rotate and left shift: LOAD 8'h81 then ROL -> 8'h03. LOAD 8'h81 then ROR -> 8'hC0. LOAD 8'h81 then SHL with sInL=0 -> 8'h02, sOutL=0.
4. Frame: CLEAR, then 8 SHR with sInR = 1,0,1,1,0,0,1,0 -> after the 8th edge Q=8'h4D and `frame`=1 for exactly one cycle. Continued shifting -> next pulse after the 16th shift only.
5. Enable and restart:
   - 4 SHR, then `en`=0 for 3 cycles with mode=SHR, then 4 SHR -> Q held while `en`=0 and `frame` on the 8th executed shift.
   - Repeat with a LOAD after shift 5 -> `frame` only 8 shifts after the LOAD.
6. Priority and reserved mode: `rst` asserted on the same edge as LOAD 8'h55 -> Q=8'h00. Mode 111 with `en`=1 -> Q and `cnt` unchanged, `frame`=0.

Source files
------------

// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared types for the universal shift register.
//   usr_mode_t : 3-bit operation select driven on the bus 'mode' signal.
//   is_shift() : true for the four modes that move bits and advance the
//                frame counter.
// ---------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_ROR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111   // reserved, treated as HOLD
    } usr_mode_t;

    function automatic logic is_shift(input usr_mode_t m);
        return (m == MODE_SHR) || (m == MODE_SHL) ||
               (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/usr_if.sv
// ---------------------------------------------------------------------------
// usr_if
// Control/data bundle of the universal shift register.
//   en, mode, D, sInR, sInL : driven by the master (user logic / bench)
//   Q, sOutR, sOutL, frame  : driven by the slave (the shift register)
// clk and rst are kept as plain ports on the modules.
// ---------------------------------------------------------------------------
interface usr_if #(
    parameter int WIDTH = 8
);
    import usr_pkg::*;

    logic             en;
    usr_mode_t        mode;
    logic [WIDTH-1:0] D;
    logic             sInR;
    logic             sInL;
    logic [WIDTH-1:0] Q;
    logic             sOutR;
    logic             sOutL;
    logic             frame;

    modport master (
        output en, mode, D, sInR, sInL,
        input  Q, sOutR, sOutL, frame
    );

    modport slave (
        input  en, mode, D, sInR, sInL,
        output Q, sOutR, sOutL, frame
    );

endinterface

// File: rtl/usr_frame_counter.sv
// ---------------------------------------------------------------------------
// usr_frame_counter
// Counts executed shifts modulo WIDTH and pulses 'frame' for one cycle at the
// edge that executes the WIDTH-th shift since the last restart.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   step    : a shift/rotate is executed at this edge
//   restart : a LOAD or CLEAR is executed at this edge
//   frame   : registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module usr_frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic restart,
    output logic frame
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            frame <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            frame <= 1'b0;
        end else if (step) begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                frame <= 1'b1;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                frame <= 1'b0;
            end
        end else begin
            // Hold, reserved mode or en low: count is kept, pulse drops.
            frame <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
// WIDTH-bit shift register with bidirectional shift/rotate, parallel load,
// synchronous clear, clock enable and a frame-complete pulse.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (Q <= RESET_VALUE, frame cleared)
//   bus : usr_if.slave
//         en/mode select the operation, D is load data, sInR/sInL are the
//         serial inputs, Q is the register, sOutR = Q[0], sOutL = Q[WIDTH-1],
//         frame pulses after WIDTH shifts since the last load/clear.
// ---------------------------------------------------------------------------
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     rst,
    usr_if.slave     bus
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             step;
    logic             restart;

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        q_next  = q_reg;
        step    = 1'b0;
        restart = 1'b0;
        if (bus.en) begin
            step = is_shift(bus.mode);
            case (bus.mode)
                MODE_SHR:   q_next = {bus.sInR, q_reg[WIDTH-1:1]};
                MODE_SHL:   q_next = {q_reg[WIDTH-2:0], bus.sInL};
                MODE_ROR:   q_next = {q_reg[0], q_reg[WIDTH-1:1]};
                MODE_ROL:   q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                MODE_LOAD: begin
                    q_next  = bus.D;
                    restart = 1'b1;
                end
                MODE_CLEAR: begin
                    q_next  = '0;
                    restart = 1'b1;
                end
                default:    q_next = q_reg;   // HOLD and reserved
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_reg <= RESET_VALUE;
        else     q_reg <= q_next;
    end

    usr_frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_counter (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .restart (restart),
        .frame   (bus.frame)
    );

    assign bus.Q     = q_reg;
    assign bus.sOutR = q_reg[0];
    assign bus.sOutL = q_reg[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register
// Directed self-checking bench for universal_shift_register, WIDTH=8.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_universal_shift_register;
    import usr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    usr_if #(.WIDTH(8)) bus ();

    universal_shift_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply one operation for one clock and sample just after the edge.
    task automatic op(input usr_mode_t m, input logic [7:0] d = 8'h00,
                      input logic s_r = 1'b0, input logic s_l = 1'b0,
                      input logic e = 1'b1);
        @(negedge clk);
        bus.en   = e;
        bus.mode = m;
        bus.D    = d;
        bus.sInR = s_r;
        bus.sInL = s_l;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bits4;
    logic [7:0] exp_q;

    initial begin
        bus.en   = 1'b0;
        bus.mode = MODE_HOLD;
        bus.D    = 8'h00;
        bus.sInR = 1'b0;
        bus.sInL = 1'b0;

        // ---- 1. reset ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", 32'(bus.Q), 32'h00);
        check("reset_frame", 32'(bus.frame), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        op(MODE_LOAD, 8'hFF);
        check("load_ff", 32'(bus.Q), 32'hFF);
        @(negedge clk);
        bus.mode = MODE_LOAD;
        bus.D    = 8'hFF;
        #1 rst = 1'b1;
        #1;
        check("async_rst_q", 32'(bus.Q), 32'h00);
        check("async_rst_frame", 32'(bus.frame), 32'h0);
        @(posedge clk);
        #1;
        check("rst_over_edge_q", 32'(bus.Q), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        op(MODE_LOAD, 8'h3C);
        check("first_edge_load", 32'(bus.Q), 32'h3C);

        // ---- 2. right shift ----
        op(MODE_LOAD, 8'hA5);
        check("shr_load", 32'(bus.Q), 32'hA5);
        check("shr_sout0", 32'(bus.sOutR), 32'h1);
        op(MODE_SHR, 8'h00, 1'b1);
        check("shr1_q", 32'(bus.Q), 32'hD2);
        check("shr1_sout", 32'(bus.sOutR), 32'h0);
        op(MODE_SHR, 8'h00, 1'b1);
        check("shr2_q", 32'(bus.Q), 32'hE9);
        check("shr2_sout", 32'(bus.sOutR), 32'h1);
        op(MODE_SHR, 8'h00, 1'b1);
        check("shr3_q", 32'(bus.Q), 32'hF4);
        check("shr3_sout", 32'(bus.sOutR), 32'h0);

        // ---- 3. rotate and left shift ----
        op(MODE_LOAD, 8'h81);
        check("load81_soutl", 32'(bus.sOutL), 32'h1);
        op(MODE_ROL);
        check("rol_q", 32'(bus.Q), 32'h03);
        op(MODE_LOAD, 8'h81);
        op(MODE_ROR);
        check("ror_q", 32'(bus.Q), 32'hC0);
        op(MODE_LOAD, 8'h81);
        op(MODE_SHL, 8'h00, 1'b0, 1'b0);
        check("shl_q", 32'(bus.Q), 32'h02);
        check("shl_soutl", 32'(bus.sOutL), 32'h0);
        op(MODE_SHL, 8'h00, 1'b0, 1'b1);
        check("shl_sinl_q", 32'(bus.Q), 32'h05);

        // ---- 4. frame ----
        op(MODE_CLEAR);
        check("clear_q", 32'(bus.Q), 32'h00);
        bits4 = 8'b0100_1101;   // bit i is the serial bit of shift i
        for (int i = 0; i < 8; i++) begin
            op(MODE_SHR, 8'h00, bits4[i]);
            check($sformatf("frame_a%0d", i + 1), 32'(bus.frame), 32'(i == 7));
        end
        check("frame_word", 32'(bus.Q), 32'h4D);
        for (int i = 8; i < 16; i++) begin
            op(MODE_SHR, 8'h00, 1'b0);
            check($sformatf("frame_b%0d", i + 1), 32'(bus.frame), 32'(i == 15));
        end
        op(MODE_HOLD);
        check("frame_drop", 32'(bus.frame), 32'h0);

        // ---- 5a. enable low stretches a frame ----
        op(MODE_CLEAR);
        for (int i = 0; i < 4; i++) begin
            op(MODE_SHR, 8'h00, 1'b1);
            check($sformatf("en_pre%0d", i + 1), 32'(bus.frame), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            op(MODE_SHR, 8'h00, 1'b0, 1'b0, 1'b0);
            check($sformatf("en_hold_q%0d", i), 32'(bus.Q), 32'hF0);
            check($sformatf("en_hold_f%0d", i), 32'(bus.frame), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            op(MODE_SHR, 8'h00, 1'b0);
            check($sformatf("en_post%0d", i + 5), 32'(bus.frame), 32'(i == 3));
        end
        check("en_word", 32'(bus.Q), 32'h0F);

        // ---- 5b. load restarts the frame ----
        op(MODE_CLEAR);
        for (int i = 0; i < 5; i++) op(MODE_SHR, 8'h00, 1'b1);
        op(MODE_LOAD, 8'h12);
        check("restart_load_f", 32'(bus.frame), 32'h0);
        for (int i = 0; i < 8; i++) begin
            op(MODE_SHL, 8'h00, 1'b0, 1'b0);
            check($sformatf("restart_f%0d", i + 1), 32'(bus.frame), 32'(i == 7));
        end
        check("restart_word", 32'(bus.Q), 32'h00);

        // ---- 6. priority and reserved mode ----
        @(negedge clk);
        bus.en   = 1'b1;
        bus.mode = MODE_LOAD;
        bus.D    = 8'h55;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_vs_load", 32'(bus.Q), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        op(MODE_LOAD, 8'h96);
        exp_q = 8'h96;
        for (int i = 0; i < 3; i++) begin
            op(MODE_ROL);
            exp_q = {exp_q[6:0], exp_q[7]};
        end
        check("rsvd_pre_q", 32'(bus.Q), 32'(exp_q));
        for (int i = 0; i < 2; i++) begin
            op(usr_mode_t'(3'b111));
            check($sformatf("rsvd_q%0d", i), 32'(bus.Q), 32'(exp_q));
            check($sformatf("rsvd_f%0d", i), 32'(bus.frame), 32'h0);
        end
        // Count was 3 before the reserved cycles; 5 more shifts close the frame.
        for (int i = 0; i < 5; i++) begin
            op(MODE_ROL);
            exp_q = {exp_q[6:0], exp_q[7]};
            check($sformatf("rsvd_post_f%0d", i + 4), 32'(bus.frame), 32'(i == 4));
        end
        check("rsvd_word", 32'(bus.Q), 32'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
